// File: rtl/neuron_state_ctrl_pkg.sv
// Shared FSM encoding and config-word sizing helpers for the neuron controller.
package neuron_state_ctrl_pkg;

    typedef enum logic [1:0] {
        S_CFG   = 2'd0,
        S_READY = 2'd1,
        S_EVAL  = 2'd2
    } state_t;

    // Config word layout is {w[N-1:0], shift[2:0], minus_teta[P-1:0]}.
    function automatic int cfg_w_of(input int n_stage);
        return (2 ** n_stage) + 3 + (n_stage + 2);
    endfunction

    function automatic int cnt_w_of(input int n_stage);
        return $clog2(cfg_w_of(n_stage));
    endfunction

endpackage

// File: rtl/neuron_state_ctrl_neuron.sv
// Purely combinational binary-weight leaky integrate-and-fire neuron.
module neuron_state_ctrl_neuron #(
    parameter int n_stage = 2,
    localparam int N = 2 ** n_stage,
    localparam int P = n_stage + 2
) (
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_w,
    input  logic [2:0]   i_shift,
    input  logic [P-1:0] i_mteta,
    input  logic [P-1:0] i_u,
    input  logic         i_was_spike,
    output logic [P-1:0] o_u,
    output logic         o_is_spike
);

    logic signed [P-1:0] w_u_in;
    logic signed [P-1:0] w_leak;
    logic signed [P-1:0] w_base;
    logic signed [P-1:0] w_sum;
    logic signed [P-1:0] w_u_out;
    logic signed [P:0]   w_margin;

    // Active synapse adds +1 when its weight bit is set, -1 otherwise.
    // shift==0 disables leak; a spike last step restarts integration from 0.
    always_comb begin
        w_u_in = i_u;
        w_sum  = '0;
        for (int i = 0; i < N; i++) begin
            if (i_x[i]) begin
                w_sum = i_w[i] ? (w_sum + P'(1)) : (w_sum - P'(1));
            end
        end
        w_leak = w_u_in >>> i_shift;
        if (i_was_spike) begin
            w_base = '0;
        end else if (i_shift == 3'd0) begin
            w_base = w_u_in;
        end else begin
            w_base = w_u_in - w_leak;
        end
        w_u_out  = w_base + w_sum;
        w_margin = {w_u_out[P-1], w_u_out} + {i_mteta[P-1], i_mteta};
    end

    assign o_u        = w_u_out;
    assign o_is_spike = ~w_margin[P];

endmodule

// File: rtl/neuron_state_ctrl.sv
// Serial-configured neuron controller: loads parameters bit by bit, then
// evaluates one timestep per accepted step request.
module neuron_state_ctrl
    import neuron_state_ctrl_pkg::*;
#(
    parameter int n_stage = 2,
    localparam int N = 2 ** n_stage,
    localparam int P = n_stage + 2,
    localparam int CFG_W = cfg_w_of(n_stage),
    localparam int CNT_W = cnt_w_of(n_stage)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_bit,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_done,
    input  logic [N-1:0]     x_in,
    input  logic             step_valid,
    output logic             step_ready,
    output logic             spike_valid,
    output logic             spike_out,
    output logic [P-1:0]     u_state,
    output logic [7:0]       spike_count,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_bit_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [CFG_W-1:0]   r_shadow;
    logic [N-1:0]       r_w;
    logic [2:0]         r_shift;
    logic [P-1:0]       r_mteta;
    logic [N-1:0]       r_x;
    logic [P-1:0]       r_u;
    logic               r_was_spike;
    logic               r_spike_out;
    logic [7:0]         r_spike_count;
    logic               r_cfg_done;
    logic               r_spike_valid;

    logic               w_cfg_ready;
    logic               w_step_ready;
    logic               w_cfg_acc;
    logic               w_step_acc;
    logic               w_last_bit;
    logic [CFG_W-1:0]   w_shadow_nxt;
    logic [P-1:0]       w_u_out;
    logic               w_is_spike;

    // Handshake: a transfer happens on a rising edge where valid && ready; ready
    // never depends on the same cycle's transfer, only on state (and step_valid,
    // which takes priority over cfg_valid in S_READY).
    assign w_cfg_acc    = cfg_valid && w_cfg_ready;
    assign w_step_acc   = step_valid && w_step_ready;
    assign w_last_bit   = (r_bit_cnt == CNT_W'(CFG_W - 1));
    assign w_shadow_nxt = {r_shadow[CFG_W-2:0], cfg_bit};

    neuron_state_ctrl_neuron #(.n_stage(n_stage)) u_neuron (
        .i_x         (r_x),
        .i_w         (r_w),
        .i_shift     (r_shift),
        .i_mteta     (r_mteta),
        .i_u         (r_u),
        .i_was_spike (r_was_spike),
        .o_u         (w_u_out),
        .o_is_spike  (w_is_spike)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_CFG;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CFG:   if (w_cfg_acc && w_last_bit) w_state_nxt = S_READY;
            S_READY: begin
                if (w_step_acc)     w_state_nxt = S_EVAL;
                else if (w_cfg_acc) w_state_nxt = S_CFG;
            end
            S_EVAL:  w_state_nxt = S_READY;
            default: w_state_nxt = S_CFG;
        endcase
    end

    always_comb begin
        w_cfg_ready  = 1'b0;
        w_step_ready = 1'b0;
        case (r_state)
            S_CFG:   w_cfg_ready = 1'b1;
            S_READY: begin
                w_step_ready = 1'b1;
                w_cfg_ready  = !step_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt     <= '0;
            r_shadow      <= '0;
            r_w           <= '0;
            r_shift       <= '0;
            r_mteta       <= '0;
            r_x           <= '0;
            r_u           <= '0;
            r_was_spike   <= 1'b0;
            r_spike_out   <= 1'b0;
            r_spike_count <= '0;
            r_cfg_done    <= 1'b0;
            r_spike_valid <= 1'b0;
        end else begin
            r_cfg_done    <= 1'b0;
            r_spike_valid <= 1'b0;
            if (w_cfg_acc) r_shadow <= w_shadow_nxt;
            case (r_state)
                S_CFG: begin
                    if (w_cfg_acc) begin
                        if (w_last_bit) begin
                            r_w           <= w_shadow_nxt[CFG_W-1 -: N];
                            r_shift       <= w_shadow_nxt[P+2 -: 3];
                            r_mteta       <= w_shadow_nxt[P-1:0];
                            r_u           <= '0;
                            r_was_spike   <= 1'b0;
                            r_spike_count <= '0;
                            r_bit_cnt     <= '0;
                            r_cfg_done    <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_READY: begin
                    if (w_step_acc)     r_x       <= x_in;
                    else if (w_cfg_acc) r_bit_cnt <= CNT_W'(1);
                end
                S_EVAL: begin
                    r_u           <= w_u_out;
                    r_was_spike   <= w_is_spike;
                    r_spike_out   <= w_is_spike;
                    r_spike_valid <= 1'b1;
                    if (w_is_spike && (r_spike_count != 8'hFF)) begin
                        r_spike_count <= r_spike_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_ready   = w_cfg_ready;
    assign step_ready  = w_step_ready;
    assign cfg_done    = r_cfg_done;
    assign spike_valid = r_spike_valid;
    assign spike_out   = r_spike_out;
    assign u_state     = r_u;
    assign spike_count = r_spike_count;
    assign dbg_state   = r_state;
    assign dbg_bit_cnt = r_bit_cnt;

endmodule
